// File: rtl/scan_pkg.sv
// Shared types for the scan chain sequencer.
// State encoding and default chain length.
package scan_pkg;

  localparam int DEF_CHAIN_LEN = 4;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } scan_state_t;

endpackage

// File: rtl/scan_chain_controller_shift_reg.sv
// Parallel/serial shift register, MSB leaves first.
// Load has priority over shift.
module scan_shift_reg
  import scan_pkg::*;
#(
  parameter int W = DEF_CHAIN_LEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  input  logic         i_shift_en,
  input  logic         i_si,
  output logic         o_so,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_shift_en) begin
      r_q <= {r_q[W-2:0], i_si};
    end
  end

  assign o_so = r_q[W-1];
  assign o_q  = r_q;

endmodule

// File: rtl/scan_chain_controller.sv
// Loads a pattern into a scan chain, captures once,
// shifts the capture back out and compares it.
module scan_chain_controller
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
  input  logic                 clk,
  input  logic                 RESET_n,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expected_in,
  input  logic                 TDO,
  output logic                 TST,
  output logic                 TDI,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] result_out,
  output logic                 mismatch
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  scan_state_t r_state;
  scan_state_t w_nxt;

  logic [CNT_W-1:0]     r_cnt;
  logic [CHAIN_LEN-1:0] r_exp;
  logic [CHAIN_LEN-1:0] r_res;
  logic                 r_mm;
  logic                 r_tst;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_shifting;
  logic                 w_ser_so;
  logic                 w_des_so;
  logic [CHAIN_LEN-1:0] w_ser_q;
  logic [CHAIN_LEN-1:0] w_des_q;
  logic [CHAIN_LEN-1:0] w_cap;
  logic                 w_unused;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_last     = (r_cnt == LAST);
  assign w_shifting = (r_state == SHIFT_IN) ||
                      (r_state == SHIFT_OUT);

  // Final word includes the TDO bit sampled on this edge
  assign w_cap = {w_des_q[CHAIN_LEN-2:0], TDO};

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:      if (start)  w_nxt = SHIFT_IN;
      SHIFT_IN:  if (w_last) w_nxt = CAPTURE;
      CAPTURE:               w_nxt = SHIFT_OUT;
      SHIFT_OUT: if (w_last) w_nxt = DONE;
      DONE:                  w_nxt = IDLE;
      default:               w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_exp   <= '0;
      r_res   <= '0;
      r_mm    <= 1'b0;
      r_tst   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (!w_shifting || (w_nxt != r_state))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      r_tst  <= (w_nxt == SHIFT_IN) ||
                (w_nxt == SHIFT_OUT);
      r_busy <= (w_nxt != IDLE);
      r_done <= (w_nxt == DONE);
      if (w_accept)
        r_exp <= expected_in;
      if ((r_state == SHIFT_OUT) && w_last) begin
        r_res <= w_cap;
        r_mm  <= (w_cap != r_exp);
      end
    end
  end

  // Shifts in zeros, so TDI idles low once the pattern is out
  scan_shift_reg #(.W(CHAIN_LEN)) u_ser (
    .clk        (clk),
    .rst_n      (RESET_n),
    .i_load     (w_accept),
    .i_d        (pattern_in),
    .i_shift_en (r_state == SHIFT_IN),
    .i_si       (1'b0),
    .o_so       (w_ser_so),
    .o_q        (w_ser_q)
  );

  scan_shift_reg #(.W(CHAIN_LEN)) u_des (
    .clk        (clk),
    .rst_n      (RESET_n),
    .i_load     (w_accept),
    .i_d        ({CHAIN_LEN{1'b0}}),
    .i_shift_en (r_state == SHIFT_OUT),
    .i_si       (TDO),
    .o_so       (w_des_so),
    .o_q        (w_des_q)
  );

  assign w_unused = ^{w_ser_q, w_des_q[CHAIN_LEN-1], w_des_so};

  assign TST        = r_tst;
  assign TDI        = w_ser_so;
  assign busy       = r_busy;
  assign done       = r_done;
  assign result_out = r_res;
  assign mismatch   = r_mm;

endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller with a behavioural
// 4-stage scan chain attached to TST/TDI/TDO.
module tb_scan_chain_controller;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         RESET_n;
  logic         start;
  logic [N-1:0] pattern_in;
  logic [N-1:0] expected_in;
  logic         TDO;
  logic         TST;
  logic         TDI;
  logic         busy;
  logic         done;
  logic [N-1:0] result_out;
  logic         mismatch;
  logic [N-1:0] data_in;
  logic [N-1:0] chain;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (TST) chain <= {chain[N-2:0], TDI};
    else     chain <= data_in;

  assign TDO = chain[N-1];

  scan_chain_controller #(.CHAIN_LEN(N)) dut (
    .clk         (clk),
    .RESET_n     (RESET_n),
    .start       (start),
    .pattern_in  (pattern_in),
    .expected_in (expected_in),
    .TDO         (TDO),
    .TST         (TST),
    .TDI         (TDI),
    .busy        (busy),
    .done        (done),
    .result_out  (result_out),
    .mismatch    (mismatch)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic chk_idle0(input string nm);
    chk({nm, ".tst"}, {31'd0, TST}, 0);
    chk({nm, ".tdi"}, {31'd0, TDI}, 0);
    chk({nm, ".busy"}, {31'd0, busy}, 0);
    chk({nm, ".done"}, {31'd0, done}, 0);
    chk({nm, ".res"}, {28'd0, result_out}, 0);
    chk({nm, ".mm"}, {31'd0, mismatch}, 0);
  endtask

  // One full scan run; start is presented at the current negedge
  task automatic run(input string nm,
                     input logic [N-1:0] pat,
                     input logic [N-1:0] dat,
                     input logic [N-1:0] exw,
                     input logic [N-1:0] want_res,
                     input logic want_mm,
                     input int poke);
    logic [N-1:0] tdi_seq;
    logic [2*N:0] tst_seq;
    logic [2*N:0] tst_req;
    logic [N-1:0] res;
    logic [N-1:0] ch;
    logic         mm;
    logic         busy_ok;
    int           lat;
    int           ndone;
    data_in     = dat;
    pattern_in  = pat;
    expected_in = exw;
    start       = 1'b1;
    tdi_seq = '0;
    tst_seq = '0;
    tst_req = '0;
    res = '0;
    ch = '1;
    mm = 1'bx;
    lat = 0;
    ndone = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 2*N+6; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (poke != 0 && c == poke) begin
        start       = 1'b1;
        pattern_in  = ~pat;
        expected_in = ~exw;
      end
      if (poke != 0 && c == poke + 1) start = 1'b0;
      if (c <= 2*N+1) begin
        tst_seq[2*N+1-c] = TST;
        tst_req[2*N+1-c] = (c != N+1);
      end
      if (c <= N) tdi_seq[N-c] = TDI;
      if (c <= 2*N+2 && !busy) busy_ok = 1'b0;
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat = c;
          res = result_out;
          mm  = mismatch;
          ch  = chain;
        end
      end
    end
    chk({nm, ".latency"}, lat, 2*N+2);
    chk({nm, ".ndone"}, ndone, 1);
    chk({nm, ".tdi"}, {28'd0, tdi_seq}, {28'd0, pat});
    chk({nm, ".tst"}, {23'd0, tst_seq}, {23'd0, tst_req});
    chk({nm, ".busy"}, {31'd0, busy_ok}, 1);
    chk({nm, ".res"}, {28'd0, res}, {28'd0, want_res});
    chk({nm, ".mm"}, {31'd0, mm}, {31'd0, want_mm});
    chk({nm, ".chain0"}, {28'd0, ch}, 0);
    chk({nm, ".hold_res"}, {28'd0, result_out}, {28'd0, want_res});
    chk({nm, ".hold_mm"}, {31'd0, mismatch}, {31'd0, want_mm});
    chk({nm, ".idle"}, {31'd0, busy}, 0);
  endtask

  typedef struct {
    logic [N-1:0] pat;
    logic [N-1:0] dat;
    logic [N-1:0] exw;
    logic [N-1:0] res;
    logic         mm;
    int           poke;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int dc[$];
    logic [N-1:0] rp, rd, re;

    vecs[0] = '{4'hA, 4'h2, 4'h2, 4'h2, 1'b0, 0};
    vecs[1] = '{4'h3, 4'h5, 4'h4, 4'h5, 1'b1, 0};
    vecs[2] = '{4'hF, 4'h9, 4'h9, 4'h9, 1'b0, 3};
    vecs[3] = '{4'h5, 4'hC, 4'hD, 4'hC, 1'b1, 0};

    RESET_n     = 1'b0;
    start       = 1'b0;
    pattern_in  = '0;
    expected_in = '0;
    data_in     = '0;
    repeat (3) @(negedge clk);
    chk_idle0("reset");
    RESET_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle0("post_reset");

    for (int i = 0; i < 4; i++)
      run($sformatf("vec%0d", i), vecs[i].pat, vecs[i].dat,
          vecs[i].exw, vecs[i].res, vecs[i].mm, vecs[i].poke);

    for (int i = 0; i < 8; i++) begin
      rp = N'($urandom);
      rd = N'($urandom);
      re = ($urandom_range(0, 1) == 1) ? rd : N'($urandom);
      run($sformatf("rnd%0d", i), rp, rd, re, rd, rd != re, 0);
    end

    // Reset in the middle of SHIFT_OUT
    data_in     = 4'h6;
    pattern_in  = 4'h9;
    expected_in = 4'h6;
    start       = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    chk("midrst.busy_before", {31'd0, busy}, 1);
    RESET_n = 1'b0;
    #1;
    chk_idle0("midrst");
    begin
      int nd;
      nd = 0;
      repeat (2) @(negedge clk);
      RESET_n = 1'b1;
      repeat (12) begin
        @(negedge clk);
        if (done) nd++;
      end
      chk("midrst.nodone", nd, 0);
    end
    run("after_rst", 4'hC, 4'h7, 4'h7, 4'h7, 1'b0, 0);

    // start held high: one IDLE cycle between runs
    data_in     = 4'hB;
    pattern_in  = 4'h1;
    expected_in = 4'hB;
    start       = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        dc.push_back(c);
        chk($sformatf("b2b.res%0d", c), {28'd0, result_out}, 32'hB);
      end
      if (dc.size() > 0 && c == dc[$] + 1)
        chk($sformatf("b2b.gap%0d", c), {31'd0, busy}, 0);
    end
    start = 1'b0;
    chk("b2b.count", dc.size(), 3);
    for (int k = 0; k < 3 && k < dc.size(); k++)
      chk($sformatf("b2b.at%0d", k), dc[k],
          (2*N+2) + k*(2*N+3));
    repeat (12) @(negedge clk);
    chk("b2b.idle", {31'd0, busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/scan_chain_controller.md
# scan_chain_controller

Sequencer that drives and observes a `ScannableChain_4_bit`-style scan chain:
- sits directly upstream of the chain's `TST`/`TDI` inputs and downstream of its `TDO` output;
- on a `start` request it serially loads a test pattern into the chain, pulses one functional capture cycle, then shifts the captured word back out;
- presents the captured word in parallel with a compare result against an expected value.

## Interface
- `CHAIN_LEN`, 4, number of scan stages (≥2)
- `CNT_W`, `$clog2(CHAIN_LEN+1)`, bit counter width (derived, not overridden)
- `clk`  in  1  rising-edge clock
- `RESET_n`  in  1  reset, asynchronous and active-low; the single clock is `clk`
- `start`  in  1  request a scan test; accepted only in IDLE
- `pattern_in`  in  CHAIN_LEN  word to load into the chain, latched on accept
- `expected_in`  in  CHAIN_LEN  expected capture word, latched on accept
- `TDO`  in  1  serial output of last chain stage
- `TST`  out  1  chain test-mode select (1 = shift, 0 = functional/capture)
- `TDI`  out  1  serial data into chain stage 0
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when result is valid
- `result_out`  out  CHAIN_LEN  captured word; held until next accepted start
- `mismatch`  out  1  `result_out != expected`; valid with and after `done`

## Operation
- Chain model: with `TST`=1 each rising edge shifts `TDI` into stage 0 and stage i into stage i+1. `TDO` = stage CHAIN_LEN-1. With `TST`=0 the chain loads its parallel data.
- FSM states:
  - IDLE: on `start`=1, latch `pattern_in`/`expected_in`, clear counter, go to SHIFT_IN.
  - SHIFT_IN: `TST`=1; `TDI` = pattern bit CHAIN_LEN-1-k on the k-th cycle (MSB first), so stage i ends holding `pattern_in[i]`. After CHAIN_LEN cycles go to CAPTURE.
  - CAPTURE: `TST`=0 for exactly one cycle, then go to SHIFT_OUT.
  - SHIFT_OUT: `TST`=1, `TDI`=0. `TDO` is sampled on each edge into a shift-left register, so the first sample becomes the MSB. After CHAIN_LEN cycles go to DONE.
  - DONE: update `result_out` and `mismatch`, pulse `done`, go to IDLE.
- `start` is ignored while `busy`=1. No queuing.
- The chain is left holding all zeros after SHIFT_OUT.
- Reset values: `TST`=0, `TDI`=0, `busy`=0, `done`=0, `result_out`=0, `mismatch`=0, state IDLE, counter 0.
- `RESET_n` asserted mid-operation: all outputs return to reset values immediately (asynchronously). The sequence is abandoned and no `done` is issued.

## Timing
- All outputs are registered.
- If `start` is accepted at edge 0:
  - SHIFT_IN occupies cycles 1..N, with `TST`=1 visible after edge 0.
  - CAPTURE is cycle N+1.
  - SHIFT_OUT occupies cycles N+2..2N+1.
  - `done` is high during cycle 2N+2.
  - Total latency is 2N+2 cycles (10 for N=4).
- `TDO` is sampled on the same edge on which the chain shifts, so each sample is the pre-shift value.
- `start` held high through `done` is re-accepted in the IDLE cycle after DONE; there are no back-to-back starts without one IDLE cycle.
- `busy` falls in the same cycle `done` falls.
- Counter wrap: the counter counts 0..CHAIN_LEN-1 and resets on every state change. It never exceeds CHAIN_LEN-1.

## Structure
- Shared package `scan_pkg`:
  - `scan_state_t` enum {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE};
  - default `CHAIN_LEN` localparam.
- One sub-module, `scan_shift_reg`: a parameterised PISO/SIPO register with `load`, `shift_en`, serial in/out and parallel out. Two instances:
  - pattern serialiser;
  - `TDO` deserialiser.
- Top level holds the FSM, counter and compare.

## Test plan
- Reset: hold `RESET_n`=0 for 3 cycles. All outputs are 0 and `busy`=0. Release; nothing changes without `start`.
- Basic: chain data_in=4'h2, `pattern_in`=4'hA, `expected_in`=4'h2, `start` pulse.
  - `TDI` sequence 1,0,1,0.
  - `TST` pattern 1111 0 1111.
  - `done` at cycle 10, `result_out`=4'h2, `mismatch`=0.
- Mismatch: chain data_in=4'h5, `expected_in`=4'h4. Result is `result_out`=4'h5, `mismatch`=1, and it persists until the next start.
- Busy ignore: pulse `start` again at cycle 3. No restart, a single `done` at cycle 10, and pattern/expected unchanged.
- Reset mid-op: assert `RESET_n`=0 during SHIFT_OUT cycle 7. Outputs return to 0 immediately, no `done`. A new run after release gives correct results.
- Back-to-back: hold `start`=1 continuously. `done` pulses every 11 cycles, with one IDLE cycle between runs.
